// File: rtl/sprite_line_renderer_pkg.sv
// sprite_line_renderer_pkg: VGA timing, sprite geometry and FSM encoding shared by the renderer.
package sprite_line_renderer_pkg;
    localparam int H_ACTIVE = 640;
    localparam int H_SYNC   = 96;
    localparam int V_ACTIVE = 480;
    localparam int V_SYNC   = 2;
    localparam int V_TOTAL  = 525;
    localparam int SPRITE_W = 8;
    localparam int SPRITE_H = 8;
    typedef enum logic [1:0] {IDLE, FETCH, WAIT, READY} state_t;
endpackage

// File: rtl/sprite_row_shifter.sv
// sprite_row_shifter: maps a screen column onto the buffered sprite row, with clipping and horizontal mirror.
module sprite_row_shifter
    import sprite_line_renderer_pkg::*;
#(
    parameter int SCALE_LOG2 = 1
) (
    input  logic [9:0] h_count,
    input  logic [9:0] sprite_x,
    input  logic [7:0] row_buf,
    input  logic       row_valid,
    input  logic       h_mirror,
    output logic       hit
);
    localparam logic [10:0] SPAN = 11'(SPRITE_W << SCALE_LOG2);
    logic [10:0] dx;
    logic [2:0]  col;
    always_comb begin
        dx  = {1'b0, h_count} - {1'b0, sprite_x};
        col = 3'(dx >> SCALE_LOG2);
        hit = row_valid && !dx[10] && dx < SPAN && row_buf[h_mirror ? col : 3'd7 - col];
    end
endmodule

// File: rtl/sprite_line_renderer.sv
// sprite_line_renderer: fetches the next line's sprite row from ROM during h-blank
// and renders it as registered colour data aligned to the VGA counters.
module sprite_line_renderer
    import sprite_line_renderer_pkg::*;
#(
    parameter int         SCALE_LOG2 = 1,
    parameter logic [7:0] FG_COLOR   = 8'hFF,
    parameter logic [7:0] BG_COLOR   = 8'h00
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [9:0] h_count,
    input  logic [9:0] v_count,
    input  logic [9:0] sprite_x,
    input  logic [9:0] sprite_y,
    input  logic [1:0] sprite_id,
    input  logic [1:0] orientation,
    output logic       rom_read_enable,
    output logic [1:0] rom_sprite_id,
    output logic [2:0] rom_line_index,
    input  logic [7:0] rom_data,
    output logic [7:0] color_out
);
    localparam logic [10:0] SPAN_Y = 11'(SPRITE_H << SCALE_LOG2);
    state_t      state_q, state_d;
    logic [9:0]  sx_q, sy_q, next_line;
    logic [1:0]  id_q, orient_q;
    logic [7:0]  row_buf_q, row_buf_d, color_q;
    logic        row_valid_q, row_valid_d, in_range, hit;
    logic [10:0] dy;
    logic [2:0]  row;

    // Fetch targets the line after the current one, wrapping to line 0 at frame end.
    always_comb begin
        next_line = v_count == 10'(V_TOTAL - 1) ? 10'd0 : v_count + 10'd1;
        dy        = {1'b0, next_line} - {1'b0, sy_q};
        row       = 3'(dy >> SCALE_LOG2);
        in_range  = !dy[10] && dy < SPAN_Y && next_line < 10'(V_ACTIVE);
    end

    always_comb begin
        state_d         = state_q;
        row_buf_d       = row_buf_q;
        row_valid_d     = row_valid_q;
        rom_read_enable = 1'b0;
        rom_sprite_id   = 2'd0;
        rom_line_index  = 3'd0;
        case (state_q)
            IDLE:  if (h_count == 10'(H_ACTIVE)) state_d = FETCH;
            FETCH: begin
                if (in_range) begin
                    rom_read_enable = 1'b1;
                    rom_sprite_id   = id_q;
                    rom_line_index  = orient_q[1] ? 3'd7 - row : row;
                    state_d         = WAIT;
                end else begin
                    row_valid_d = 1'b0;
                    state_d     = IDLE;
                end
            end
            WAIT: begin
                row_buf_d   = rom_data;
                row_valid_d = 1'b1;
                state_d     = READY;
            end
            READY: if (h_count == 10'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    sprite_row_shifter #(.SCALE_LOG2(SCALE_LOG2)) u_shifter (
        .h_count   (h_count),
        .sprite_x  (sx_q),
        .row_buf   (row_buf_q),
        .row_valid (row_valid_q),
        .h_mirror  (orient_q[0]),
        .hit       (hit)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            sx_q        <= '0;
            sy_q        <= '0;
            id_q        <= '0;
            orient_q    <= '0;
            row_buf_q   <= '0;
            row_valid_q <= 1'b0;
            color_q     <= '0;
        end else begin
            state_q     <= state_d;
            row_buf_q   <= row_buf_d;
            row_valid_q <= row_valid_d;
            // Shadow sprite state once per frame so a frame never mixes two positions.
            if (h_count == 10'd0 && v_count == 10'(V_ACTIVE)) begin
                sx_q     <= sprite_x;
                sy_q     <= sprite_y;
                id_q     <= sprite_id;
                orient_q <= orientation;
            end
            color_q <= (h_count >= 10'(H_ACTIVE) || v_count >= 10'(V_ACTIVE)) ? 8'h00 :
                       hit ? FG_COLOR : BG_COLOR;
        end
    end

    assign color_out = color_q;
endmodule
